// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin controller sharing a single shift-add multiplier
// between NREQ requesters, with response holding and a WAIT timeout.
module mul_share_ctrl #(
  parameter  int unsigned WIDTH   = 4,
  parameter  int unsigned NREQ    = 2,
  parameter  int unsigned TIMEOUT = 64,
  localparam int unsigned IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic                  rsp_valid_o,
  output logic [IDW-1:0]        rsp_id_o,
  output logic [2*WIDTH-1:0]    rsp_p_o,
  output logic                  rsp_err_o,
  input  logic                  rsp_ready_i,
  output logic                  mul_start_o,
  output logic [WIDTH-1:0]      mul_a_o,
  output logic [WIDTH-1:0]      mul_b_o,
  input  logic [2*WIDTH-1:0]    mul_p_i,
  input  logic                  mul_done_i,
  output logic                  busy_o
);

  localparam int unsigned CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t             state_q;
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     id_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [CW-1:0]      wait_cnt_q;
  logic               first_q;
  logic               rsp_valid_q;
  logic [IDW-1:0]     rsp_id_q;
  logic [2*WIDTH-1:0] rsp_p_q;
  logic               rsp_err_q;
  logic               mul_start_q;
  logic               busy_q;

  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic [IDW-1:0]     ptr_d;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  int unsigned        cand;
  logic               timeout_hit;

  // Round-robin search of req_valid starting at ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    ptr_d       = ptr_q;
    sel_a       = '0;
    sel_b       = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(ptr_q) + k) % NREQ;
      if (!grant_found && req_valid_i[IDW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(cand);
        ptr_d       = (cand == NREQ - 1) ? '0 : IDW'(cand + 1);
        sel_a       = req_a_i[cand*WIDTH +: WIDTH];
        sel_b       = req_b_i[cand*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot grant, only offered while idle and out of reset.
  always_comb begin
    req_ready_o = '0;
    if (!rst && (state_q == S_IDLE) && grant_found) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt_q == TO_LAST);

  // Controller FSM: grant, start pulse, wait for done or timeout, hold response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      wait_cnt_q  <= '0;
      first_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
      rsp_err_q   <= 1'b0;
      mul_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            a_q         <= sel_a;
            b_q         <= sel_b;
            id_q        <= grant_idx;
            ptr_q       <= ptr_d;
            mul_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_START;
          end
        end
        S_START: begin
          mul_start_q <= 1'b0;
          wait_cnt_q  <= '0;
          first_q     <= 1'b1;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          first_q    <= 1'b0;
          wait_cnt_q <= wait_cnt_q + CW'(1);
          // A done seen in the first WAIT cycle may be left over from the previous op.
          if (!first_q && mul_done_i) begin
            rsp_p_q     <= mul_p_i;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (timeout_hit) begin
            rsp_p_q     <= '0;
            rsp_err_q   <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_p_o     = rsp_p_q;
  assign rsp_err_o   = rsp_err_q;
  assign mul_start_o = mul_start_q;
  assign mul_a_o     = a_q;
  assign mul_b_o     = b_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl: directed vectors, multi-cycle sequences and a randomized
// run checked against a transaction-level round-robin model.
module tb_mul_share_ctrl;

  localparam int unsigned W    = 4;
  localparam int unsigned NREQ = 2;
  localparam int unsigned TO   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [W-1:0]    ra [NREQ];
  logic [W-1:0]    rb [NREQ];
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0] req_ready;
  logic            rsp_valid;
  logic            rsp_id;
  logic [2*W-1:0]  rsp_p;
  logic            rsp_err;
  logic            rsp_ready;
  logic            mul_start;
  logic [W-1:0]    mul_a;
  logic [W-1:0]    mul_b;
  logic [2*W-1:0]  mul_p;
  logic            mul_done;
  logic            busy;

  assign req_a = {ra[1], ra[0]};
  assign req_b = {rb[1], rb[0]};

  mul_share_ctrl #(.WIDTH(W), .NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
    .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_p_o(rsp_p), .rsp_err_o(rsp_err),
    .rsp_ready_i(rsp_ready),
    .mul_start_o(mul_start), .mul_a_o(mul_a), .mul_b_o(mul_b),
    .mul_p_i(mul_p), .mul_done_i(mul_done),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: mode 0 = real multiply after mul_lat cycles (done held),
  // mode 1 = never done, mode 2 = done stuck high with product 42.
  int          mode    = 0;
  int          mul_lat = 2;
  logic        stub_done;
  logic [7:0]  stub_p;
  int          stub_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_done <= 1'b0;
      stub_p    <= '0;
      stub_cnt  <= 0;
    end else if (mul_start) begin
      stub_done <= 1'b0;
      stub_p    <= {4'b0, mul_a} * {4'b0, mul_b};
      stub_cnt  <= mul_lat - 1;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_done <= 1'b1;
    end
  end

  assign mul_done = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : stub_done;
  assign mul_p    = (mode == 2) ? 8'd42 : stub_p;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_id"},    32'(rsp_id), 0);
    chk({tag, "_rsp_p"},     32'(rsp_p), 0);
    chk({tag, "_rsp_err"},   32'(rsp_err), 0);
    chk({tag, "_mul_start"}, 32'(mul_start), 0);
    chk({tag, "_mul_a"},     32'(mul_a), 0);
    chk({tag, "_mul_b"},     32'(mul_b), 0);
    chk({tag, "_busy"},      32'(busy), 0);
  endtask

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
    int         md;
    int         lat;
    logic [7:0] exp_p;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  // Single request from one requester; latency counted from grant cycle to rsp_valid.
  task automatic do_op(input string tag, input vec_t v);
    int n;
    int lat;
    mode      = v.md;
    mul_lat   = v.lat;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid       = '0;
    req_valid[v.id] = 1'b1;
    ra[v.id]        = v.a;
    rb[v.id]        = v.b;
    n = 0;
    #1;
    while (req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
    chk({tag, "_grant"}, 32'(req_ready), 32'(req_valid));
    @(negedge clk);
    req_valid = '0;
    chk({tag, "_start"}, 32'(mul_start), 1);
    chk({tag, "_mul_a"}, 32'(mul_a), 32'(v.a));
    chk({tag, "_mul_b"}, 32'(mul_b), 32'(v.b));
    chk({tag, "_busy"},  32'(busy), 1);
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, "_id"},      32'(rsp_id), 32'(v.id));
    chk({tag, "_p"},       32'(rsp_p), 32'(v.exp_p));
    chk({tag, "_err"},     32'(rsp_err), 32'(v.exp_err));
    @(negedge clk);
    chk({tag, "_done_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_done_busy"},  32'(busy), 0);
  endtask

  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v, input int last);
    logic [NREQ-1:0] r;
    int j;
    r = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (last + k) % NREQ;
      if (r == '0 && v[j]) r[j] = 1'b1;
    end
    return r;
  endfunction

  vec_t vecs [8];

  // Random-phase model state
  logic [NREQ-1:0] exp_rdy;
  bit              outst, prev_grant, seen;
  int              last_gid, eid, elat, cyc;
  logic [3:0]      ea, eb;
  logic [7:0]      ep;
  logic            ee;

  initial begin
    int n;
    vecs[0] = '{0, 4'd6,  4'd3,  0, 3, 8'd18,  1'b0, 5};
    vecs[1] = '{1, 4'd15, 4'd15, 0, 4, 8'd225, 1'b0, 6};
    vecs[2] = '{0, 4'd0,  4'd9,  0, 2, 8'd0,   1'b0, 4};
    vecs[3] = '{1, 4'd7,  4'd5,  1, 2, 8'd0,   1'b1, TO + 2};
    vecs[4] = '{0, 4'd9,  4'd9,  0, 5, 8'd81,  1'b0, 7};
    vecs[5] = '{1, 4'd3,  4'd3,  2, 2, 8'd42,  1'b0, 4};
    vecs[6] = '{1, 4'd15, 4'd1,  0, 2, 8'd15,  1'b0, 4};
    vecs[7] = '{0, 4'd12, 4'd13, 0, 6, 8'd156, 1'b0, 8};

    // Reset state, with requests already asserted
    rst = 1'b1; rsp_ready = 1'b0; req_valid = 2'b11;
    ra[0] = 4'd1; rb[0] = 4'd1; ra[1] = 4'd2; rb[1] = 4'd2;
    @(negedge clk);
    chk_zero("rst");
    rst = 1'b0; req_valid = '0;

    for (int i = 0; i < 8; i++) do_op($sformatf("v%0d", i), vecs[i]);

    // Reset in the middle of WAIT
    mode = 1; rsp_ready = 1'b1;
    @(negedge clk);
    ra[0] = 4'd5; rb[0] = 4'd5; req_valid = 2'b01;
    n = 0; #1;
    while (req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
    chk("mid_grant", 32'(req_ready), 1);
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    chk("mid_mul_a", 32'(mul_a), 5);
    req_valid = 2'b11; rst = 1'b1;
    #1;
    chk_zero("mid");
    @(negedge clk);
    rst = 1'b0; req_valid = '0; mode = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("mid_no_rsp", 32'(rsp_valid), 0);
    end
    req_valid = 2'b11; #1;
    chk("mid_ptr_reset", 32'(req_ready), 1);
    req_valid = '0; #1;
    chk("mid_drop", 32'(req_ready), 0);
    do_op("mid_after", '{1, 4'd15, 4'd2, 0, 3, 8'd30, 1'b0, 5});

    // Contention: both requesters held, grants must alternate
    mode = 0; mul_lat = 3; rsp_ready = 1'b1;
    @(negedge clk);
    ra[0] = 4'd6; rb[0] = 4'd3; ra[1] = 4'd15; rb[1] = 4'd15; req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      n = 0; #1;
      while (req_ready == '0 && n < 30) begin @(negedge clk); #1; n++; end
      chk("cont_grant", 32'(req_ready), (k % 2 == 0) ? 1 : 2);
      @(negedge clk);
      n = 0;
      while (!rsp_valid && n < 30) begin @(negedge clk); n++; end
      chk("cont_id", 32'(rsp_id), 32'(k % 2));
      chk("cont_p", 32'(rsp_p), (k % 2 == 0) ? 18 : 225);
      @(negedge clk);
    end
    req_valid = '0;

    // Backpressure: response held 10 cycles while another request waits
    rsp_ready = 1'b0; mul_lat = 3;
    @(negedge clk);
    req_valid = 2'b01;
    n = 0; #1;
    while (req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
    chk("bp_grant", 32'(req_ready), 1);
    @(negedge clk); req_valid = 2'b10;
    n = 0;
    while (!rsp_valid && n < 30) begin @(negedge clk); n++; end
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_id", 32'(rsp_id), 0);
      chk("bp_p", 32'(rsp_p), 18);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_start", 32'(mul_start), 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_valid", 32'(rsp_valid), 0);
    chk("bp_rel_busy", 32'(busy), 0);
    chk("bp_next_grant", 32'(req_ready), 2);
    @(negedge clk); req_valid = '0;
    chk("bp_next_start", 32'(mul_start), 1);
    chk("bp_next_a", 32'(mul_a), 15);
    n = 0;
    while (!rsp_valid && n < 30) begin @(negedge clk); n++; end
    chk("bp_next_id", 32'(rsp_id), 1);
    chk("bp_next_p", 32'(rsp_p), 225);
    @(negedge clk);

    // Randomized run against the transaction-level model
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    outst = 0; prev_grant = 0; seen = 0; last_gid = NREQ - 1;
    eid = 0; elat = 0; cyc = 0; ea = '0; eb = '0; ep = '0; ee = 1'b0;
    for (int it = 0; it < 1500; it++) begin
      @(negedge clk);
      if (prev_grant) begin
        chk("r_start", 32'(mul_start), 1);
        chk("r_mul_a", 32'(mul_a), 32'(ea));
        chk("r_mul_b", 32'(mul_b), 32'(eb));
      end else begin
        chk("r_start_idle", 32'(mul_start), 0);
      end
      if (outst) cyc++;
      if (rsp_valid) begin
        chk("r_rsp_owner", 32'(outst), 1);
        chk("r_id", 32'(rsp_id), 32'(eid));
        chk("r_p", 32'(rsp_p), 32'(ep));
        chk("r_err", 32'(rsp_err), 32'(ee));
        if (!seen) chk("r_latency", 32'(cyc), 32'(elat));
        seen = 1;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (prev_grant && i == eid) begin
          if ($urandom_range(0, 3) == 0) begin ra[i] = 4'($urandom); rb[i] = 4'($urandom); end
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_valid[i] = 1'b1; ra[i] = 4'($urandom); rb[i] = 4'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 4) == 0) begin
          ra[i] = 4'($urandom); rb[i] = 4'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 1) == 1);
      #1;
      exp_rdy = outst ? '0 : rr_pick(req_valid, last_gid);
      chk("r_req_ready", 32'(req_ready), 32'(exp_rdy));
      prev_grant = 0;
      if (outst) begin
        if (rsp_valid && rsp_ready) outst = 0;
      end else if (exp_rdy != '0) begin
        eid = exp_rdy[1] ? 1 : 0;
        ea = ra[eid]; eb = rb[eid];
        case ($urandom_range(0, 7))
          0:       mode = 1;
          1:       mode = 2;
          default: mode = 0;
        endcase
        mul_lat = $urandom_range(2, 6);
        if (mode == 1) begin elat = TO + 2; ep = 8'd0; ee = 1'b1; end
        else if (mode == 2) begin elat = 4; ep = 8'd42; ee = 1'b0; end
        else begin elat = mul_lat + 2; ep = 8'(int'(ea) * int'(eb)); ee = 1'b0; end
        outst = 1; seen = 0; cyc = 0; last_gid = eid; prev_grant = 1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
